// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and constants for the RV32I fetch path.
package rv32_pkg;
  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {BOOT, FETCH, KILL, HOLD} fetch_state_e;
endpackage

// File: rtl/redirect_latch.sv
// redirect_latch: holds a redirect target that arrives while a fetch is in
// flight, and computes the effective target of the current redirect.
// Optional feature: PCSEQ_MISALIGN_TRAP_EN (misaligned targets trap instead
// of being silently aligned).
module redirect_latch
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            consume,
  output logic [XLEN-1:0] eff_target,
  output logic [XLEN-1:0] held_target,
  output logic            pending,
  output logic            trap
);

`ifdef PCSEQ_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |redirect_target[1:0];
  assign eff_target = misaligned ? TRAP_VECTOR : redirect_target;

  // Trap pulses the cycle after a misaligned redirect is accepted.
  always_ff @(posedge clk) begin
    if (reset) trap <= 1'b0;
    else       trap <= redirect_valid & misaligned;
  end
`else
  // Low target bits are dropped, so the trap vector has no use here.
  logic unused_bits;
  assign unused_bits = ^{TRAP_VECTOR, redirect_target[1:0]};
  assign eff_target  = {redirect_target[XLEN-1:2], 2'b00};
  assign trap        = 1'b0;
`endif

  // Capture a redirect that cannot be applied this cycle; a later redirect
  // before the in-flight fetch retires simply overwrites the target.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= 1'b0;
      held_target <= '0;
    end else if (redirect_valid && !consume) begin
      pending     <= 1'b1;
      held_target <= eff_target;
    end else if (consume) begin
      pending     <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, runs one-outstanding req/ack reads to
// IMEM and hands {instr, pc} to decode, honouring stalls and redirects.
// Optional feature: PCSEQ_MISALIGN_TRAP_EN (see redirect_latch).
module fetch_sequencer
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Redirect_Valid,
  input  logic [XLEN-1:0] Redirect_Target,
  output logic            IMem_Req,
  output logic [XLEN-1:0] IMem_Addr,
  input  logic            IMem_Ack,
  input  logic [XLEN-1:0] IMem_Rdata,
  output logic            Instr_Valid,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] Instr_PC,
  output logic            Trap
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            ack_ok, consume, deliver, pending;
  logic [XLEN-1:0] eff_target, held_target;

  // The request is a pure function of state, so it cannot drop before Ack.
  assign IMem_Req  = (state == FETCH) || (state == KILL);
  assign IMem_Addr = pc;
  assign ack_ok    = IMem_Ack & IMem_Req;
  // Redirects are applied immediately unless a fetch is still in flight.
  assign consume   = ack_ok || (state == BOOT) || (state == HOLD);

  redirect_latch #(.TRAP_VECTOR(TRAP_VECTOR)) u_redirect (
    .clk             (Clk),
    .reset           (Reset),
    .redirect_valid  (Redirect_Valid),
    .redirect_target (Redirect_Target),
    .consume         (consume),
    .eff_target      (eff_target),
    .held_target     (held_target),
    .pending         (pending),
    .trap            (Trap)
  );

  // Next-state and next-PC selection; Redirect outranks Stall everywhere.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    deliver = 1'b0;
    unique case (state)
      BOOT, HOLD: begin
        if (Redirect_Valid) pc_n = eff_target;
        state_n = Stall ? HOLD : FETCH;
      end
      FETCH: begin
        if (ack_ok) begin
          if (Redirect_Valid) begin
            pc_n = eff_target;
          end else begin
            deliver = 1'b1;
            pc_n    = pc + PC_STEP;
          end
          state_n = Stall ? HOLD : FETCH;
        end else if (Redirect_Valid) begin
          state_n = KILL;
        end
      end
      KILL: begin
        if (ack_ok) begin
          if (Redirect_Valid) pc_n = eff_target;
          else if (pending)   pc_n = held_target;
          state_n = Stall ? HOLD : FETCH;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  // State, PC and the decode-facing output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      Instr_Valid <= 1'b0;
      Instr       <= RV32_NOP;
      Instr_PC    <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      Instr_Valid <= deliver;
      if (deliver) begin
        Instr    <= IMem_Rdata;
        Instr_PC <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus a randomized run scored against
// a transaction-level model of the fetch rules.
module tb_fetch_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] TV  = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Redirect_Valid = 1'b0;
  logic [31:0] Redirect_Target = '0;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack = 1'b0;
  logic [31:0] IMem_Rdata = '0;
  logic        Instr_Valid;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        Trap;

  always #5 Clk = ~Clk;

  fetch_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
    .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
    .IMem_Ack(IMem_Ack), .IMem_Rdata(IMem_Rdata),
    .Instr_Valid(Instr_Valid), .Instr(Instr), .Instr_PC(Instr_PC), .Trap(Trap)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;   // IMEM answers after Req has been seen for lat+1 cycles
  int cnt      = 0;

  // Reference model: architectural fetch PC plus the one in-flight request.
  logic [31:0] m_pc = RV, m_addr = RV, m_tgt = RV;
  logic        m_out = 1'b0, m_killed = 1'b0;
  logic        e_valid = 1'b0, e_trap = 1'b0, e_req = 1'b0;
  logic [31:0] e_instr = NOP, e_ipc = '0;

  function automatic logic [31:0] eff_tgt(input logic [31:0] t);
`ifdef PCSEQ_MISALIGN_TRAP_EN
    return (t[1:0] != 2'b00) ? TV : t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic logic mis(input logic [31:0] t);
`ifdef PCSEQ_MISALIGN_TRAP_EN
    return t[1:0] != 2'b00;
`else
    return (t[1:0] != 2'b00) && 1'b0;
`endif
  endfunction

  // Advance one clock: fold this cycle's inputs into the model, cross the
  // edge, then let the IMEM model decide Ack for the new cycle.
  task automatic tick();
    logic [31:0] t;
    if (Reset) begin
      m_pc = RV; m_out = 1'b0; m_killed = 1'b0;
      e_valid = 1'b0; e_trap = 1'b0; e_req = 1'b0;
    end else begin
      t       = eff_tgt(Redirect_Target);
      e_valid = 1'b0;
      e_trap  = Redirect_Valid && mis(Redirect_Target);
      if (IMem_Req) begin
        if (!m_out) begin m_out = 1'b1; m_addr = m_pc; end
        if (Redirect_Valid) begin m_killed = 1'b1; m_tgt = t; end
        if (IMem_Ack) begin
          if (m_killed) m_pc = m_tgt;
          else begin
            e_valid = 1'b1; e_instr = IMem_Rdata; e_ipc = m_addr;
            m_pc = m_addr + 32'd4;
          end
          m_out = 1'b0; m_killed = 1'b0;
        end
      end else if (Redirect_Valid) begin
        m_pc = t;
      end
      e_req = m_out || !Stall;
    end
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
    IMem_Ack = 1'b0;
    if (IMem_Req) begin
      cnt++;
      if (cnt > lat) begin IMem_Ack = 1'b1; IMem_Rdata = $urandom; cnt = 0; end
    end else begin
      cnt = 0;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; Stall = 1'b0; Redirect_Valid = 1'b0; lat = 1;
    tick(); tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Stall = 1'($urandom); Redirect_Valid = 1'($urandom);
      Redirect_Target = $urandom;
      tick();
      n_checks++;
      if ({IMem_Req, Instr_Valid, Trap} !== 3'b000)
        begin n_fail++; $display("FAIL reset_ctl: req/valid/trap=%b want 000", {IMem_Req, Instr_Valid, Trap}); end
      n_checks++;
      if (IMem_Addr !== RV)
        begin n_fail++; $display("FAIL reset_addr: got %h want %h", IMem_Addr, RV); end
      n_checks++;
      if (Instr !== NOP || Instr_PC !== 32'h0)
        begin n_fail++; $display("FAIL reset_instr: got %h/%h want %h/0", Instr, Instr_PC, NOP); end
    end
    Reset = 1'b0; Stall = 1'b0; Redirect_Valid = 1'b0;
    tick();
    n_checks++;
    if (IMem_Req !== 1'b1 || IMem_Addr !== RV)
      begin n_fail++; $display("FAIL boot_fetch: req=%b addr=%h want 1/%h", IMem_Req, IMem_Addr, RV); end
  endtask

  task automatic test_stream();
    int nv = 0, last = 0, k = 0, g = 0;
    do_reset();
    while (nv < 4 && g < 40) begin
      tick(); g++;
      if (Instr_Valid) begin
        n_checks++;
        if (Instr_PC !== 32'(nv * 4) || Instr !== e_instr)
          begin n_fail++; $display("FAIL stream_pc: got %h/%h want %h/%h", Instr_PC, Instr, 32'(nv * 4), e_instr); end
        if (nv > 0) begin
          n_checks++;
          if (cyc - last != 2)
            begin n_fail++; $display("FAIL stream_gap: got %0d want 2", cyc - last); end
        end
        last = cyc; nv++;
      end
    end
    n_checks++;
    if (nv != 4) begin n_fail++; $display("FAIL stream_count: got %0d want 4", nv); end
    // 0x10 is now requested; slow IMEM to three idle cycles before Ack.
    lat = 3; g = 0;
    do begin
      n_checks++;
      if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h10)
        begin n_fail++; $display("FAIL slow_hold: req=%b addr=%h want 1/10", IMem_Req, IMem_Addr); end
      k++; tick(); g++;
    end while (!Instr_Valid && g < 20);
    n_checks++;
    if (k != 4) begin n_fail++; $display("FAIL slow_cycles: got %0d want 4", k); end
    n_checks++;
    if (Instr_Valid !== 1'b1 || Instr_PC !== 32'h10)
      begin n_fail++; $display("FAIL slow_deliver: valid=%b pc=%h want 1/10", Instr_Valid, Instr_PC); end
  endtask

  task automatic test_redirect();
    int g = 0, nv = 0;
    do_reset();
    while (!(IMem_Req && IMem_Addr == 32'h10) && g < 40) begin tick(); g++; end
    lat = 3;
    Redirect_Valid = 1'b1; Redirect_Target = 32'h200;
    tick();
    Redirect_Valid = 1'b0; g = 0;
    while (!(IMem_Req && IMem_Addr == 32'h200) && g < 20) begin
      if (Instr_Valid) nv++;
      tick(); g++;
    end
    if (Instr_Valid) nv++;
    n_checks++;
    if (g >= 20) begin n_fail++; $display("FAIL kill_target: addr=%h want 200", IMem_Addr); end
    n_checks++;
    if (nv != 0) begin n_fail++; $display("FAIL kill_drop: got %0d valids want 0", nv); end
    // Redirect landing in the same cycle as the Ack of 0x20.
    do_reset(); g = 0;
    while (!(IMem_Req && IMem_Addr == 32'h20 && IMem_Ack) && g < 40) begin tick(); g++; end
    Redirect_Valid = 1'b1; Redirect_Target = 32'h80;
    tick();
    Redirect_Valid = 1'b0;
    n_checks++;
    if (Instr_Valid !== 1'b0) begin n_fail++; $display("FAIL ackredir_drop: valid=%b want 0", Instr_Valid); end
    n_checks++;
    if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h80)
      begin n_fail++; $display("FAIL ackredir_addr: req=%b addr=%h want 1/80", IMem_Req, IMem_Addr); end
    g = 0;
    while (!Instr_Valid && g < 10) begin tick(); g++; end
    n_checks++;
    if (Instr_PC !== 32'h80 || Instr !== e_instr)
      begin n_fail++; $display("FAIL ackredir_deliver: got %h/%h want 80/%h", Instr_PC, Instr, e_instr); end
  endtask

  task automatic test_stall();
    int g = 0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    Stall = 1'b1;
    while (IMem_Req && g < 10) begin tick(); g++; end
    n_checks++;
    if (IMem_Req !== 1'b0) begin n_fail++; $display("FAIL stall_enter: req=%b want 0", IMem_Req); end
    for (int i = 0; i < 4; i++) begin
      Redirect_Valid = (i == 0); Redirect_Target = 32'h40;
      tick();
      n_checks++;
      if (IMem_Req !== 1'b0) begin n_fail++; $display("FAIL stall_hold: cycle %0d req=%b want 0", i, IMem_Req); end
    end
    Redirect_Valid = 1'b0; Stall = 1'b0;
    tick();
    n_checks++;
    if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h40)
      begin n_fail++; $display("FAIL stall_release: req=%b addr=%h want 1/40", IMem_Req, IMem_Addr); end
  endtask

  task automatic test_corner();
    int g = 0;
    logic want_trap;
`ifdef PCSEQ_MISALIGN_TRAP_EN
    want_trap = 1'b1;
`else
    want_trap = 1'b0;
`endif
    do_reset();
    while (!(IMem_Req && IMem_Ack) && g < 10) begin tick(); g++; end
    Redirect_Valid = 1'b1; Redirect_Target = 32'hFFFF_FFFC;
    tick();
    Redirect_Valid = 1'b0; g = 0;
    while (!Instr_Valid && g < 10) begin tick(); g++; end
    n_checks++;
    if (Instr_PC !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h want fffffffc", Instr_PC); end
    n_checks++;
    if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0)
      begin n_fail++; $display("FAIL wrap_next: req=%b addr=%h want 1/0", IMem_Req, IMem_Addr); end
    // Misaligned target.
    g = 0;
    while (!(IMem_Req && IMem_Ack) && g < 10) begin tick(); g++; end
    Redirect_Valid = 1'b1; Redirect_Target = 32'h102;
    tick();
    Redirect_Valid = 1'b0;
    n_checks++;
    if (Trap !== want_trap) begin n_fail++; $display("FAIL trap_pulse: got %b want %b", Trap, want_trap); end
    n_checks++;
    if (IMem_Req !== 1'b1 || IMem_Addr !== TV)
      begin n_fail++; $display("FAIL trap_addr: req=%b addr=%h want 1/%h", IMem_Req, IMem_Addr, TV); end
    // Reset while a killed fetch is waiting, with its Ack in the reset cycle.
    lat = 3;
    Redirect_Valid = 1'b1; Redirect_Target = 32'h300;
    tick();
    Redirect_Valid = 1'b0;
    n_checks++;
    if (Trap !== 1'b0) begin n_fail++; $display("FAIL trap_width: got %b want 0", Trap); end
    g = 0;
    while (!IMem_Ack && g < 10) begin tick(); g++; end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_checks++;
    if (IMem_Req !== 1'b0 || IMem_Addr !== RV || Instr_Valid !== 1'b0)
      begin n_fail++; $display("FAIL kill_reset: req=%b addr=%h valid=%b want 0/%h/0", IMem_Req, IMem_Addr, Instr_Valid, RV); end
    IMem_Ack = 1'b1; IMem_Rdata = 32'hDEAD_BEEF;   // stray Ack with no request
    tick();
    n_checks++;
    if (Instr_Valid !== 1'b0 || IMem_Req !== 1'b1 || IMem_Addr !== RV)
      begin n_fail++; $display("FAIL stray_ack: valid=%b req=%b addr=%h want 0/1/%h", Instr_Valid, IMem_Req, IMem_Addr, RV); end
  endtask

  task automatic test_random();
    logic [31:0] want_addr;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      Reset           = ($urandom_range(63) == 0);
      Stall           = ($urandom_range(9) < 3);
      Redirect_Valid  = ($urandom_range(7) == 0);
      Redirect_Target = $urandom;
      if ($urandom_range(1) == 0) Redirect_Target[1:0] = 2'b00;
      lat = int'($urandom_range(3));
      tick();
      want_addr = m_out ? m_addr : m_pc;
      n_checks++;
      if (IMem_Req !== e_req)
        begin n_fail++; $display("FAIL rnd_req: cyc %0d got %b want %b", cyc, IMem_Req, e_req); end
      n_checks++;
      if (IMem_Req && IMem_Addr !== want_addr)
        begin n_fail++; $display("FAIL rnd_addr: cyc %0d got %h want %h", cyc, IMem_Addr, want_addr); end
      n_checks++;
      if (Instr_Valid !== e_valid)
        begin n_fail++; $display("FAIL rnd_valid: cyc %0d got %b want %b", cyc, Instr_Valid, e_valid); end
      n_checks++;
      if (e_valid && (Instr !== e_instr || Instr_PC !== e_ipc))
        begin n_fail++; $display("FAIL rnd_instr: cyc %0d got %h/%h want %h/%h", cyc, Instr, Instr_PC, e_instr, e_ipc); end
      n_checks++;
      if (Trap !== e_trap)
        begin n_fail++; $display("FAIL rnd_trap: cyc %0d got %b want %b", cyc, Trap, e_trap); end
    end
    Reset = 1'b0; Stall = 1'b0; Redirect_Valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_redirect();
    test_stall();
    test_corner();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
